// File: rtl/range_clamp_stage.sv
// Multi-channel range-control stage: optional rounding right-shift, then saturate / wrap / threshold,
// in a two-stage valid/ready pipeline with per-beat saturation flags and a sticky saturation counter.
module range_clamp_stage #(
    parameter int NUM_CH = 3,
    parameter int IN_W   = 10,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 1,
    parameter int ROUND  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_reset_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [NUM_CH*IN_W-1:0]  i_data,
    input  logic [1:0]              i_mode,
    input  logic [OUT_W-1:0]        i_min,
    input  logic [OUT_W-1:0]        i_max,
    input  logic [OUT_W-1:0]        i_thr,
    input  logic                    i_clear,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [NUM_CH*OUT_W-1:0] o_data,
    output logic [NUM_CH-1:0]       o_sat_hi,
    output logic [NUM_CH-1:0]       o_sat_lo,
    output logic [CNT_W-1:0]        o_sat_count
);

    localparam int V_W     = IN_W - SHIFT + 1;
    localparam int CMP_W   = (V_W > OUT_W) ? V_W : OUT_W;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [IN_W:0] RND_ONE = 1;
    localparam logic [IN_W:0] RND_ADD = (ROUND != 0 && SHIFT > 0) ? (RND_ONE << RND_POS) : RND_ONE ^ RND_ONE;

    typedef enum logic [1:0] {
        MODE_SAT  = 2'b00,
        MODE_WRAP = 2'b01,
        MODE_THR  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    // Stage-1 registers: shifted channel values plus the configuration that travels with the beat
    logic                         r_s1_valid;
    logic [NUM_CH-1:0][V_W-1:0]   r_s1_v;
    mode_t                        r_s1_mode;
    logic [OUT_W-1:0]             r_s1_min;
    logic [OUT_W-1:0]             r_s1_max;
    logic [OUT_W-1:0]             r_s1_thr;

    logic                         r_o_valid;
    logic [NUM_CH*OUT_W-1:0]      r_o_data;
    logic [NUM_CH-1:0]            r_sat_hi;
    logic [NUM_CH-1:0]            r_sat_lo;
    logic [CNT_W-1:0]             r_sat_count;

    logic [NUM_CH-1:0][V_W-1:0]   w_s1_v;
    logic [NUM_CH*OUT_W-1:0]      w_s2_data;
    logic [NUM_CH-1:0]            w_s2_hi;
    logic [NUM_CH-1:0]            w_s2_lo;
    logic                         w_s2_advance;
    logic                         w_ready;
    logic                         w_out_fire;
    logic                         w_sat_any;

    assign w_s2_advance = !r_o_valid || i_ready;
    assign w_ready      = !r_s1_valid || w_s2_advance;
    assign w_out_fire   = r_o_valid && i_ready;
    assign w_sat_any    = |{r_sat_hi, r_sat_lo};

    genvar ch;
    for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [IN_W:0]      w_sum;
        logic [CMP_W-1:0]   w_v;
        logic [CMP_W-1:0]   w_min;
        logic [CMP_W-1:0]   w_max;
        logic [CMP_W-1:0]   w_thr;
        logic [OUT_W-1:0]   w_out;
        logic               w_hi;
        logic               w_lo;

        // One extra bit of headroom makes the rounding add overflow-free
        assign w_sum      = {1'b0, i_data[ch*IN_W +: IN_W]} + RND_ADD;
        assign w_s1_v[ch] = V_W'(w_sum >> SHIFT);

        assign w_v   = CMP_W'(r_s1_v[ch]);
        assign w_min = CMP_W'(r_s1_min);
        assign w_max = CMP_W'(r_s1_max);
        assign w_thr = CMP_W'(r_s1_thr);

        always_comb begin
            // NOTE: every output of this block gets a default first so no path can infer a latch.
            w_out = '0;
            w_hi  = 1'b0;
            w_lo  = 1'b0;
            case (r_s1_mode)
                MODE_WRAP: w_out = w_v[OUT_W-1:0];
                MODE_THR:  w_out = (w_v >= w_thr) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
                default: begin
                    // An inverted window (min > max) collapses onto max
                    if (w_v > w_max) begin
                        w_out = r_s1_max;
                        w_hi  = 1'b1;
                    end else if (w_v < w_min) begin
                        w_out = (r_s1_min > r_s1_max) ? r_s1_max : r_s1_min;
                        w_lo  = 1'b1;
                    end else begin
                        w_out = w_v[OUT_W-1:0];
                    end
                end
            endcase
        end

        assign w_s2_data[ch*OUT_W +: OUT_W] = w_out;
        assign w_s2_hi[ch]                  = w_hi;
        assign w_s2_lo[ch]                  = w_lo;
    end

    // NOTE: the stage-1 datapath is qualified by r_s1_valid, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_ready && i_valid) begin
            r_s1_v    <= w_s1_v;
            r_s1_mode <= mode_t'(i_mode);
            r_s1_min  <= i_min;
            r_s1_max  <= i_max;
            r_s1_thr  <= i_thr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_s1_valid  <= 1'b0;
            r_o_valid   <= 1'b0;
            r_o_data    <= '0;
            r_sat_hi    <= '0;
            r_sat_lo    <= '0;
            r_sat_count <= '0;
        end else begin
            if (w_ready) begin
                r_s1_valid <= i_valid;
            end
            if (w_s2_advance) begin
                r_o_valid <= r_s1_valid;
            end
            if (w_s2_advance && r_s1_valid) begin
                r_o_data <= w_s2_data;
                r_sat_hi <= w_s2_hi;
                r_sat_lo <= w_s2_lo;
            end
            if (i_clear) begin
                r_sat_count <= '0;
            end else if (w_out_fire && w_sat_any && (r_sat_count != {CNT_W{1'b1}})) begin
                r_sat_count <= r_sat_count + CNT_W'(1);
            end
        end
    end

    assign o_ready     = w_ready;
    assign o_valid     = r_o_valid;
    assign o_data      = r_o_data;
    assign o_sat_hi    = r_sat_hi;
    assign o_sat_lo    = r_sat_lo;
    assign o_sat_count = r_sat_count;

endmodule

// File: tb/tb_range_clamp_stage.sv
// Directed bench for range_clamp_stage: a scoreboard queue holds modelled beats pushed on acceptance
// and compared on output transfer; a second instance with CNT_W=4 exercises the sticky counter.
module tb_range_clamp_stage;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_valid;
    logic [29:0] i_data;
    logic [1:0]  i_mode;
    logic [7:0]  i_min;
    logic [7:0]  i_max;
    logic [7:0]  i_thr;
    logic        i_clear;
    logic        i_ready;

    logic        o_ready;
    logic        o_valid;
    logic [23:0] o_data;
    logic [2:0]  o_sat_hi;
    logic [2:0]  o_sat_lo;
    logic [15:0] o_sat_count;

    logic        o_ready4;
    logic        o_valid4;
    logic [23:0] o_data4;
    logic [2:0]  o_sat_hi4;
    logic [2:0]  o_sat_lo4;
    logic [3:0]  o_sat_count4;

    typedef struct packed {
        logic [23:0] data;
        logic [2:0]  hi;
        logic [2:0]  lo;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   n_out = 0;

    always #5 i_clk = ~i_clk;

    range_clamp_stage #(.NUM_CH(3), .IN_W(10), .OUT_W(8), .SHIFT(1), .ROUND(1), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_data(i_data), .i_mode(i_mode), .i_min(i_min), .i_max(i_max), .i_thr(i_thr),
        .i_clear(i_clear), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
        .o_sat_hi(o_sat_hi), .o_sat_lo(o_sat_lo), .o_sat_count(o_sat_count)
    );

    range_clamp_stage #(.NUM_CH(3), .IN_W(10), .OUT_W(8), .SHIFT(1), .ROUND(1), .CNT_W(4)) dut4 (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready4),
        .i_data(i_data), .i_mode(i_mode), .i_min(i_min), .i_max(i_max), .i_thr(i_thr),
        .i_clear(i_clear), .o_valid(o_valid4), .i_ready(i_ready), .o_data(o_data4),
        .o_sat_hi(o_sat_hi4), .o_sat_lo(o_sat_lo4), .o_sat_count(o_sat_count4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] pk(input int c0, input int c1, input int c2);
        return {c2[9:0], c1[9:0], c0[9:0]};
    endfunction

    // Reference model: round-half-up shift by one, then the selected range mode
    function automatic exp_t model(input logic [29:0] d, input logic [1:0] m,
                                   input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] th);
        exp_t e;
        e = '0;
        for (int c = 0; c < 3; c++) begin
            logic [10:0] x;
            logic [10:0] v;
            logic [7:0]  r;
            x = {1'b0, d[c*10 +: 10]};
            v = (x + 11'd1) >> 1;
            r = '0;
            if (m == 2'b01) begin
                r = v[7:0];
            end else if (m == 2'b10) begin
                r = (v >= {3'b000, th}) ? 8'hFF : 8'h00;
            end else if (v > {3'b000, mx}) begin
                r = mx;
                e.hi[c] = 1'b1;
            end else if (v < {3'b000, mn}) begin
                r = (mn > mx) ? mx : mn;
                e.lo[c] = 1'b1;
            end else begin
                r = v[7:0];
            end
            e.data[c*8 +: 8] = r;
        end
        return e;
    endfunction

    // Scoreboard: push on acceptance, pop and compare on output transfer
    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            sb.delete();
        end else begin
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    check("beat_vs_sb", sb.size(), 1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", o_data, e.data);
                    check("out_sat_hi", o_sat_hi, e.hi);
                    check("out_sat_lo", o_sat_lo, e.lo);
                    check("out_data_cnt4", o_data4, e.data);
                end
                n_out++;
            end
            if (i_valid && o_ready) begin
                sb.push_back(model(i_data, i_mode, i_min, i_max, i_thr));
            end
        end
    end

    task automatic send(input logic [29:0] d, input logic [1:0] m,
                        input logic [7:0] mn, input logic [7:0] mx, input logic [7:0] th);
        int k;
        i_data  = d;
        i_mode  = m;
        i_min   = mn;
        i_max   = mx;
        i_thr   = th;
        i_valid = 1'b1;
        k = 0;
        @(negedge i_clk);
        while (!o_ready && k < 50) begin
            @(negedge i_clk);
            k++;
        end
        if (k >= 50) check("send_timeout", o_ready, 1);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        check("drain", sb.size(), 0);
        @(negedge i_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] held;
        logic [2:0]  held_hi;
        logic        seen_nr;
        int          n0;

        i_reset_n = 1'b0;
        i_valid   = 1'b0;
        i_data    = '0;
        i_mode    = 2'b00;
        i_min     = 8'd0;
        i_max     = 8'd255;
        i_thr     = 8'd0;
        i_clear   = 1'b0;
        i_ready   = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_hi", o_sat_hi, 0);
        check("rst_lo", o_sat_lo, 0);
        check("rst_count", o_sat_count, 0);
        check("rst_ready", o_ready, 1);
        @(posedge i_clk);
        #1;

        // Saturate with default window, plus two-cycle latency
        send(pk(5, 511, 1023), 2'b00, 8'd0, 8'd255, 8'd0);
        @(negedge i_clk);
        check("lat_not_yet", o_valid, 0);
        @(negedge i_clk);
        check("lat_valid", o_valid, 1);
        check("sat_data", o_data, 24'hFFFF03);
        check("sat_hi", o_sat_hi, 3'b110);
        @(negedge i_clk);
        check("sat_count1", o_sat_count, 1);
        @(posedge i_clk);
        #1;

        send(pk(20, 400, 402), 2'b00, 8'd16, 8'd200, 8'd0);
        wait_drain();
        check("win_count", o_sat_count, 2);
        @(posedge i_clk);
        #1;

        send(pk(512, 510, 3), 2'b01, 8'd16, 8'd200, 8'd0);
        send(pk(255, 253, 0), 2'b10, 8'd0, 8'd255, 8'd128);
        wait_drain();
        check("wrap_thr_count", o_sat_count, 2);
        @(posedge i_clk);
        #1;

        // Backpressure: 8 back-to-back beats, 3-cycle stall mid-stream
        n0 = n_out;
        seen_nr = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) send(pk(20 * k + 2, 700 + k, 3 * k), 2'b00, 8'd0, 8'd255, 8'd0);
            end
            begin
                repeat (3) @(posedge i_clk);
                #1;
                i_ready = 1'b0;
                @(negedge i_clk);
                held    = o_data;
                held_hi = o_sat_hi;
                seen_nr = !o_ready;
                repeat (2) begin
                    @(negedge i_clk);
                    check("stall_hold_data", o_data, held);
                    check("stall_hold_hi", o_sat_hi, held_hi);
                    check("stall_valid", o_valid, 1);
                    seen_nr = seen_nr | !o_ready;
                end
                check("stall_oready_low", seen_nr, 1);
                @(posedge i_clk);
                #1;
                i_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_beats", n_out - n0, 8);
        check("bp_count", o_sat_count, 10);
        @(posedge i_clk);
        #1;

        // Sticky counter: 20 saturating beats
        for (int k = 0; k < 20; k++) send(pk(0, 1023, 0), 2'b00, 8'd0, 8'd255, 8'd0);
        wait_drain();
        check("cnt4_sticky", o_sat_count4, 15);
        check("cnt16_after20", o_sat_count, 30);
        @(posedge i_clk);
        #1;

        // Clear coincident with a saturating transfer
        send(pk(0, 1023, 0), 2'b00, 8'd0, 8'd255, 8'd0);
        @(posedge i_clk);
        #1;
        i_clear = 1'b1;
        @(posedge i_clk);
        #1;
        i_clear = 1'b0;
        @(negedge i_clk);
        check("clear_wins16", o_sat_count, 0);
        check("clear_wins4", o_sat_count4, 0);
        @(posedge i_clk);
        #1;

        // Reset mid-stream discards in-flight beats and the pending count
        send(pk(0, 1023, 0), 2'b00, 8'd0, 8'd255, 8'd0);
        send(pk(4, 1023, 8), 2'b00, 8'd0, 8'd255, 8'd0);
        i_reset_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        @(negedge i_clk);
        check("mrst_valid", o_valid, 0);
        check("mrst_count", o_sat_count, 0);
        check("mrst_data", o_data, 0);
        check("mrst_ready", o_ready, 1);
        repeat (2) @(negedge i_clk);
        check("mrst_no_beat", o_valid, 0);
        @(posedge i_clk);
        #1;

        // Reserved mode acts as saturate; inverted window collapses onto max
        send(pk(100, 200, 300), 2'b11, 8'd10, 8'd50, 8'd0);
        send(pk(100, 200, 600), 2'b00, 8'd200, 8'd100, 8'd0);
        wait_drain();
        check("post_rst_count", o_sat_count, 2);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/range_clamp_stage.md
Name: range_clamp_stage

Overview:
Parametrised multi-channel range-control stage that converts wide unsigned per-channel results (e.g. sqrt magnitude, filter sums) to OUT_W-bit pixel channels. Optional rounding right-shift, then a selectable mode: saturate to a programmable [min,max] window, wrap, or binary threshold. Two-stage pipeline with a valid/ready handshake and backpressure, per-beat saturation flags, and a saturation event counter. Sits between the arithmetic cores and the pixel output/packer.

Parameters:
NUM_CH, 3, number of parallel channels.
IN_W, 10, input width per channel (unsigned).
OUT_W, 8, output width per channel.
SHIFT, 1, right shift applied before range control (0 = none).
ROUND, 1, 1 = round half up before the shift, 0 = truncate. Ignored when SHIFT=0.
CNT_W, 16, saturation counter width.

Ports:
i_clk  in  1  clock
i_reset_n  in  1  synchronous active-low reset
i_valid  in  1  input beat valid
o_ready  out  1  stage can accept a beat
i_data  in  NUM_CH*IN_W  packed channels; ch0 in the LSBs
i_mode  in  2  00 saturate, 01 wrap, 10 threshold, 11 reserved (treated as 00)
i_min  in  OUT_W  lower clamp bound
i_max  in  OUT_W  upper clamp bound
i_thr  in  OUT_W  threshold level for mode 10
i_clear  in  1  synchronous clear of o_sat_count
o_valid  out  1  output beat valid
i_ready  in  1  downstream accepts a beat
o_data  out  NUM_CH*OUT_W  packed result channels
o_sat_hi  out  NUM_CH  per-channel "clamped at max", aligned with o_data
o_sat_lo  out  NUM_CH  per-channel "clamped at min", aligned with o_data
o_sat_count  out  CNT_W  number of output beats with any sat flag set

Behaviour:
- Reset (i_reset_n=0 at a clock edge): o_valid=0, o_data=0, o_sat_hi=0, o_sat_lo=0, o_sat_count=0, internal stage-1 valid=0. Reset mid-stream discards all in-flight beats.
- Handshake: a beat transfers on an edge where valid and ready are both 1. o_data, o_sat_hi and o_sat_lo hold stable while o_valid=1 and i_ready=0.
- Stage-1 advances when stage 2 is empty or i_ready=1. o_ready = !s1_valid || s1_advance (combinational from i_ready). Full throughput is one beat per cycle.
- Latency: an accepted beat appears on o_valid 2 cycles later when there is no stall.
- Config sampling: i_mode, i_min, i_max and i_thr are sampled with the beat in stage 1 and travel with it. A config change never alters an in-flight beat.
- Stage 1 (per channel): v = ROUND ? (x + 2^(SHIFT-1)) >> SHIFT : x >> SHIFT. The add is computed in IN_W+1 bits, so there is no overflow. The result width is IN_W-SHIFT+1.
- Stage 2, mode 00: i_min and i_max are zero-extended.
  - v > i_max → i_max, sat_hi=1.
  - else v < i_min → i_min, sat_lo=1.
  - else v.
  - If i_min > i_max, the output is i_max. sat_hi=1 if v > i_max; otherwise sat_lo=1.
- Stage 2, mode 01: output the low OUT_W bits of v. Sat flags are 0.
- Stage 2, mode 10: v >= i_thr → 2^OUT_W-1, else 0. Sat flags are 0.
- Counter: increments by 1 on each output transfer (o_valid && i_ready) whose beat has any sat_hi or sat_lo bit set. The counter sticks at all-ones and does not wrap.
  - i_clear=1 sets it to 0.
  - When clear and increment occur in the same cycle, clear wins and the result is 0.
- Stalled beats count only once, at transfer.
- Bubbles (i_valid=0) produce no output beat. o_data keeps its last value when o_valid=0.

Test Plan:
- Saturate, defaults, i_min=0, i_max=255: ch0=5, ch1=511, ch2=1023 → o_data ch0=3, ch1=255, ch2=255; o_sat_hi=3'b110; o_valid 2 cycles after accept; o_sat_count=1.
- Window clamp, i_min=16, i_max=200: ch0=20 (v=10), ch1=400 (v=200), ch2=402 (v=201) → 16/200/200; o_sat_lo=3'b001; o_sat_hi=3'b100.
- Wrap mode: ch0=512 (v=256), ch1=510 (v=255), ch2=3 (v=2) → 0/255/2; flags 0; count unchanged.
- Threshold mode, i_thr=128: ch0=255 (v=128), ch1=253 (v=127), ch2=0 → 255/0/0.
- Backpressure: stream 8 back-to-back beats, each with sat_hi on ch1. Hold i_ready=0 for 3 cycles mid-stream → o_ready drops once the pipe is full, o_data stays stable, all 8 beats emerge in order with none lost or duplicated, and o_sat_count=8.
- Counter edges: CNT_W=4, 20 saturating beats → count sticks at 15. Assert i_clear in the same cycle as a saturating transfer → count=0. Assert reset mid-stream → o_valid=0 and count=0 on the next cycle.
